if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, presents it combinationally to the instruction ROM, and registers the returned word with its PC+4 into the IF/ID pipeline register. Handles reset, exception and interrupt vectoring, EX-stage branch and ID-stage jump redirects, load-use stalls and flushes. PC bit 31 is the supervisor flag; the ROM ignores it and decodes word index from addr[30:2].

## Interface

- `RESET_VEC`, 32'h8000_0000, PC after reset
- `IRQ_VEC`, 32'h8000_0004, interrupt entry
- `EXC_VEC`, 32'h8000_0008, exception (illegal instruction) entry
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  load-use hazard from ID; hold PC and IF/ID
- `branch_taken`  in  1  resolved taken branch in EX
- `branch_target`  in  32  full target, bit 31 included
- `jump`  in  1  j/jal/jr/jalr decoded in ID
- `jump_target`  in  32  full target, bit 31 included (jr may clear it)
- `irq`  in  1  level interrupt request from timer/peripherals
- `exception`  in  1  illegal-instruction pulse from ID
- `inst_addr`  out  32  to ROM addr; equals PC register
- `inst_data`  in  32  ROM data, combinational from `inst_addr`
- `ifid_inst`  out  32  registered instruction
- `ifid_pc_plus4`  out  32  registered PC+4 of that instruction
- `ifid_valid`  out  1  0 = bubble
- `irq_ack`  out  1  one-cycle pulse when interrupt taken
- `epc`  out  32  return address + 4 for $k0, valid when `irq_ack` or `exc_ack`
- `exc_ack`  out  1  one-cycle pulse when exception taken

## Operation

- PC+4 arithmetic: `{pc[31], pc[30:0] + 31'd4}`; bit 31 never changes on sequential fetch; bits [30:0] wrap modulo 2^31.
- Next-PC priority, highest first (all sampled at the same edge):
  1. `reset`: PC←RESET_VEC; IF/ID cleared.
  2. `exception`: PC←EXC_VEC; flush; `exc_ack`=1; `epc` = current PC (handler subtracts 4, resumes at PC−4, i.e. the faulting instruction in ID).
  3. `irq` && pc[31]==0: PC←IRQ_VEC; flush; `irq_ack`=1; `epc` = (branch_target if branch_taken, else jump_target if jump && !stall, else PC) + 4 with bit 31 kept from that address.
  4. `branch_taken`: PC←branch_target; flush. Overrides `stall` and `jump`.
  5. `stall`: PC and IF/ID hold; `jump` ignored.
  6. `jump`: PC←jump_target; flush.
  7. default: PC←PC+4; IF/ID←{inst_data, PC+4, valid=1}.
- Flush: `ifid_inst`←32'h0000_0000 (sll $0 nop), `ifid_pc_plus4`←0, `ifid_valid`←0.
- `irq` is masked while pc[31]==1 (kernel mode, including during handler); a pending level request is taken on the first cycle after return to a user address.
- ROM returns 0 for out-of-range addresses; the stage fetches it as a nop, no special handling.

## Timing

- Reset values: PC=RESET_VEC, `inst_addr`=RESET_VEC, `ifid_inst`=0, `ifid_pc_plus4`=0, `ifid_valid`=0, `irq_ack`=0, `exc_ack`=0, `epc`=0.
- `inst_addr` follows PC with zero latency; instruction fetched in cycle N appears on `ifid_*` in cycle N+1.
- Redirect penalty: branch 2 bubbles (ID instruction and fetch flushed by EX/ID logic plus this stage), jump 1 bubble, from this stage's view one flushed IF/ID slot per redirect.
- `irq_ack`/`exc_ack` high exactly one cycle, registered; `epc` registered together and held until the next ack.
- Stall of any length: `ifid_*` and PC bit-identical each held cycle; release resumes with the held PC.
- Reset asserted mid-stall or mid-redirect: reset wins that edge, all outputs to reset values next cycle.

## Test plan

- Reset 3 cycles, release -> `inst_addr` 0x80000000, 0x80000004, 0x80000008…; `ifid_valid` 0 first cycle, then 1 with `ifid_pc_plus4`=0x80000004.
- Stall 2 cycles at PC 0x0000_0010 -> PC and `ifid_*` frozen 2 cycles; then PC 0x14 with `ifid_inst` from 0x10 held then advanced.
- branch_taken+jump+stall same cycle, branch_target 0x40 -> PC 0x40, `ifid_valid` 0; jump with stall alone -> ignored.
- irq at user PC 0x0000_0020, no redirect -> PC 0x80000004, `irq_ack` 1 cycle, `epc`=0x24; irq held high at PC 0x8000_0010 -> no ack.
- exception and irq same cycle at PC 0x30 -> PC 0x80000008, `exc_ack`=1, `irq_ack`=0, `epc`=0x30.
- PC 0x7FFF_FFFC sequential -> next PC 0x0000_0000 (bit 31 preserved 0, no carry into bit 31).

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and loads the IF/ID register.
// Resolves reset, exception, interrupt, branch, stall and jump with a fixed priority.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        irq,
  input  logic        exception,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        irq_ack,
  output logic [31:0] epc,
  output logic        exc_ack
);

  localparam int unsigned W = 32;

  // Sequential increment keeps the supervisor bit; low 31 bits wrap.
  function automatic logic [W-1:0] pc_inc(input logic [W-1:0] a);
    return {a[W-1], a[W-2:0] + 31'd4};
  endfunction

  logic [W-1:0] pc;
  logic [W-1:0] pc_nxt;
  logic [W-1:0] inst_nxt;
  logic [W-1:0] pc4_nxt;
  logic         valid_nxt;
  logic         irq_ack_nxt;
  logic         exc_ack_nxt;
  logic [W-1:0] epc_nxt;
  logic [W-1:0] ret_addr;
  logic         flush;

  assign inst_addr = pc;

  // Next-PC selection and IF/ID update, highest priority first.
  always_comb begin
    pc_nxt      = pc;
    inst_nxt    = ifid_inst;
    pc4_nxt     = ifid_pc_plus4;
    valid_nxt   = ifid_valid;
    irq_ack_nxt = 1'b0;
    exc_ack_nxt = 1'b0;
    epc_nxt     = epc;
    flush       = 1'b0;

    // Address the interrupted stream would have fetched next.
    if (branch_taken)        ret_addr = branch_target;
    else if (jump && !stall) ret_addr = jump_target;
    else                     ret_addr = pc;

    if (exception) begin
      pc_nxt      = EXC_VEC;
      flush       = 1'b1;
      exc_ack_nxt = 1'b1;
      epc_nxt     = pc;
    end else if (irq && !pc[W-1]) begin
      pc_nxt      = IRQ_VEC;
      flush       = 1'b1;
      irq_ack_nxt = 1'b1;
      epc_nxt     = pc_inc(ret_addr);
    end else if (branch_taken) begin
      pc_nxt = branch_target;
      flush  = 1'b1;
    end else if (stall) begin
      pc_nxt = pc;
    end else if (jump) begin
      pc_nxt = jump_target;
      flush  = 1'b1;
    end else begin
      pc_nxt    = pc_inc(pc);
      inst_nxt  = inst_data;
      pc4_nxt   = pc_inc(pc);
      valid_nxt = 1'b1;
    end

    if (flush) begin
      inst_nxt  = '0;
      pc4_nxt   = '0;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VEC;
      ifid_inst     <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
      irq_ack       <= 1'b0;
      exc_ack       <= 1'b0;
      epc           <= '0;
    end else begin
      pc            <= pc_nxt;
      ifid_inst     <= inst_nxt;
      ifid_pc_plus4 <= pc4_nxt;
      ifid_valid    <= valid_nxt;
      irq_ack       <= irq_ack_nxt;
      exc_ack       <= exc_ack_nxt;
      epc           <= epc_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; a tiny ROM model returns an address-derived word.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        irq;
  logic        exception;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        irq_ack;
  logic [31:0] epc;
  logic        exc_ack;

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .irq(irq), .exception(exception),
    .inst_addr(inst_addr), .inst_data(inst_data),
    .ifid_inst(ifid_inst), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
    .irq_ack(irq_ack), .epc(epc), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;

  // ROM stand-in: ignores bit 31, word index from addr[30:2].
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {3'b101, a[30:2]};
  endfunction
  assign inst_data = rom(inst_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] target);
    jump = 1'b1; jump_target = target;
    step();
    jump = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (inst_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got %h want 80000000", inst_addr); end
    checks++; if ({ifid_valid, irq_ack, exc_ack} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ifid_valid, irq_ack, exc_ack}); end
    checks++; if ({ifid_inst, ifid_pc_plus4, epc} !== 96'h0) begin errors++; $display("FAIL reset_regs got %h want 0", {ifid_inst, ifid_pc_plus4, epc}); end
    reset = 1'b0;
    step();
    checks++; if (inst_addr !== 32'h8000_0004) begin errors++; $display("FAIL seq1_addr got %h want 80000004", inst_addr); end
    checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h8000_0004) begin errors++; $display("FAIL seq1_ifid got v=%b pc4=%h want v=1 pc4=80000004", ifid_valid, ifid_pc_plus4); end
    checks++; if (ifid_inst !== 32'hA000_0000) begin errors++; $display("FAIL seq1_inst got %h want a0000000", ifid_inst); end
    step();
    checks++; if (inst_addr !== 32'h8000_0008 || ifid_pc_plus4 !== 32'h8000_0008) begin errors++; $display("FAIL seq2 got addr=%h pc4=%h want 80000008/80000008", inst_addr, ifid_pc_plus4); end
  endtask

  task automatic test_stall();
    go_to(32'h0000_000C);
    checks++; if (inst_addr !== 32'h0000_000C || ifid_valid !== 1'b0) begin errors++; $display("FAIL jump_redirect got addr=%h v=%b want 0000000c/0", inst_addr, ifid_valid); end
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin jump = 1'b1; jump_target = 32'h0000_0200; end
      step();
      checks++; if (inst_addr !== 32'h0000_0010 || ifid_inst !== 32'hA000_0003 || ifid_pc_plus4 !== 32'h0000_0010 || ifid_valid !== 1'b1)
        begin errors++; $display("FAIL stall_hold%0d got addr=%h inst=%h pc4=%h v=%b want 00000010/a0000003/00000010/1", i, inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid); end
    end
    stall = 1'b0; jump = 1'b0;
    step();
    checks++; if (inst_addr !== 32'h0000_0014 || ifid_inst !== 32'hA000_0004 || ifid_pc_plus4 !== 32'h0000_0014)
      begin errors++; $display("FAIL stall_release got addr=%h inst=%h pc4=%h want 00000014/a0000004/00000014", inst_addr, ifid_inst, ifid_pc_plus4); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    jump = 1'b1; jump_target = 32'h0000_0080; stall = 1'b1;
    step();
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    checks++; if (inst_addr !== 32'h0000_0040) begin errors++; $display("FAIL branch_pc got %h want 00000040", inst_addr); end
    checks++; if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL branch_flush got v=%b inst=%h pc4=%h want 0/0/0", ifid_valid, ifid_inst, ifid_pc_plus4); end
  endtask

  task automatic test_irq();
    go_to(32'h0000_0020);
    irq = 1'b1;
    step();
    irq = 1'b0;
    checks++; if (inst_addr !== 32'h8000_0004 || irq_ack !== 1'b1 || exc_ack !== 1'b0) begin errors++; $display("FAIL irq_take got addr=%h ack=%b exc=%b want 80000004/1/0", inst_addr, irq_ack, exc_ack); end
    checks++; if (epc !== 32'h0000_0024 || ifid_valid !== 1'b0) begin errors++; $display("FAIL irq_epc got epc=%h v=%b want 00000024/0", epc, ifid_valid); end
    step();
    checks++; if (irq_ack !== 1'b0 || epc !== 32'h0000_0024 || inst_addr !== 32'h8000_0008) begin errors++; $display("FAIL irq_pulse got ack=%b epc=%h addr=%h want 0/00000024/80000008", irq_ack, epc, inst_addr); end
    go_to(32'h8000_0010);
    irq = 1'b1;
    repeat (2) step();
    checks++; if (irq_ack !== 1'b0 || inst_addr !== 32'h8000_0018) begin errors++; $display("FAIL irq_masked got ack=%b addr=%h want 0/80000018", irq_ack, inst_addr); end
    // Return to user space with the request still pending.
    jump = 1'b1; jump_target = 32'h0000_0050;
    step();
    jump = 1'b0;
    checks++; if (irq_ack !== 1'b0 || inst_addr !== 32'h0000_0050) begin errors++; $display("FAIL irq_return got ack=%b addr=%h want 0/00000050", irq_ack, inst_addr); end
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    step();
    branch_taken = 1'b0; irq = 1'b0;
    checks++; if (irq_ack !== 1'b1 || epc !== 32'h0000_0104 || inst_addr !== 32'h8000_0004) begin errors++; $display("FAIL irq_branch got ack=%b epc=%h addr=%h want 1/00000104/80000004", irq_ack, epc, inst_addr); end
    go_to(32'h0000_0060);
    irq = 1'b1; jump = 1'b1; jump_target = 32'h0000_0300; stall = 1'b1;
    step();
    irq = 1'b0; jump = 1'b0; stall = 1'b0;
    checks++; if (irq_ack !== 1'b1 || epc !== 32'h0000_0064) begin errors++; $display("FAIL irq_jump_stall got ack=%b epc=%h want 1/00000064", irq_ack, epc); end
    go_to(32'h0000_0070);
    irq = 1'b1; jump = 1'b1; jump_target = 32'h0000_0300;
    step();
    irq = 1'b0; jump = 1'b0;
    checks++; if (irq_ack !== 1'b1 || epc !== 32'h0000_0304) begin errors++; $display("FAIL irq_jump got ack=%b epc=%h want 1/00000304", irq_ack, epc); end
  endtask

  task automatic test_exception();
    go_to(32'h0000_0030);
    exception = 1'b1; irq = 1'b1;
    step();
    exception = 1'b0; irq = 1'b0;
    checks++; if (inst_addr !== 32'h8000_0008 || exc_ack !== 1'b1 || irq_ack !== 1'b0) begin errors++; $display("FAIL exc_take got addr=%h exc=%b irq=%b want 80000008/1/0", inst_addr, exc_ack, irq_ack); end
    checks++; if (epc !== 32'h0000_0030 || ifid_valid !== 1'b0) begin errors++; $display("FAIL exc_epc got epc=%h v=%b want 00000030/0", epc, ifid_valid); end
    step();
    checks++; if (exc_ack !== 1'b0 || epc !== 32'h0000_0030) begin errors++; $display("FAIL exc_pulse got exc=%b epc=%h want 0/00000030", exc_ack, epc); end
  endtask

  task automatic test_wrap();
    go_to(32'h7FFF_FFFC);
    step();
    checks++; if (inst_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_user_pc got %h want 00000000", inst_addr); end
    checks++; if (ifid_pc_plus4 !== 32'h0000_0000 || ifid_inst !== 32'hBFFF_FFFF || ifid_valid !== 1'b1) begin errors++; $display("FAIL wrap_user_ifid got pc4=%h inst=%h v=%b want 00000000/bfffffff/1", ifid_pc_plus4, ifid_inst, ifid_valid); end
    go_to(32'hFFFF_FFFC);
    step();
    checks++; if (inst_addr !== 32'h8000_0000 || ifid_pc_plus4 !== 32'h8000_0000) begin errors++; $display("FAIL wrap_kernel got addr=%h pc4=%h want 80000000/80000000", inst_addr, ifid_pc_plus4); end
  endtask

  task automatic test_reset_mid_stall();
    go_to(32'h0000_0090);
    step();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0400; reset = 1'b1;
    step();
    stall = 1'b0; branch_taken = 1'b0; reset = 1'b0;
    checks++; if (inst_addr !== 32'h8000_0000 || ifid_valid !== 1'b0 || ifid_pc_plus4 !== 32'h0 || ifid_inst !== 32'h0)
      begin errors++; $display("FAIL reset_mid got addr=%h v=%b pc4=%h inst=%h want 80000000/0/0/0", inst_addr, ifid_valid, ifid_pc_plus4, ifid_inst); end
    checks++; if (epc !== 32'h0 || irq_ack !== 1'b0 || exc_ack !== 1'b0) begin errors++; $display("FAIL reset_mid_epc got epc=%h acks=%b%b want 0/00", epc, irq_ack, exc_ack); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; irq = 1'b0; exception = 1'b0;
    test_reset();
    test_stall();
    test_branch();
    test_irq();
    test_exception();
    test_wrap();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
